// File: rtl/hash_out_serializer.sv
// hash_out_serializer
// Captures a wide digest on the rising edge of the hash core's ready level and
// streams it out MSB word first over a valid/ready handshake. A digest edge that
// arrives mid-stream is dropped and recorded in a sticky overrun flag, except when
// it lines up with the final handshake, in which case the new digest is chained
// directly behind the current one with no idle gap.
module hash_out_serializer #(
  parameter int unsigned l = 256,
  parameter int unsigned w = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [l-1:0] hash_text,
  input  logic         hash_ready,
  output logic [w-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         busy,
  output logic         overrun
);

  localparam int unsigned N  = l / w;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t         state_r;
  state_t         state_nxt_s;
  logic [l-1:0]   sreg_r;
  logic [l-1:0]   sreg_nxt_s;
  logic [CW-1:0]  cnt_r;
  logic [CW-1:0]  cnt_nxt_s;
  logic           rdy_q_r;
  logic           overrun_r;
  logic           overrun_nxt_s;

  logic           edge_s;
  logic           send_s;
  logic           hs_s;
  logic           last_s;

  // A new digest is signalled only by the low-to-high transition of ready.
  assign edge_s = hash_ready & ~rdy_q_r;
  assign send_s = (state_r == SEND);
  assign hs_s   = send_s & out_ready;
  assign last_s = (cnt_r == CW'(N - 1));

  // Outputs decode straight from registered state; out_ready only steers next state.
  assign out_data  = sreg_r[l-1 -: w];
  assign out_valid = send_s;
  assign busy      = send_s;
  assign out_last  = send_s & last_s;
  assign overrun   = overrun_r;

  // Next-state, shift-register and overrun decode for the IDLE/SEND machine.
  always_comb begin
    state_nxt_s   = state_r;
    sreg_nxt_s    = sreg_r;
    cnt_nxt_s     = cnt_r;
    overrun_nxt_s = overrun_r;
    case (state_r)
      IDLE: begin
        if (edge_s) begin
          sreg_nxt_s  = hash_text;
          cnt_nxt_s   = {CW{1'b0}};
          state_nxt_s = SEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SEND: begin
        if (hs_s) begin
          if (last_s) begin
            if (edge_s) begin
              // Chain the next digest behind the final word; not an overrun.
              sreg_nxt_s  = hash_text;
              cnt_nxt_s   = {CW{1'b0}};
              state_nxt_s = SEND;
            end else begin
              sreg_nxt_s  = sreg_r << w;
              cnt_nxt_s   = {CW{1'b0}};
              state_nxt_s = IDLE;
            end
          end else begin
            sreg_nxt_s    = sreg_r << w;
            cnt_nxt_s     = cnt_r + CW'(1);
            overrun_nxt_s = overrun_r | edge_s;
          end
        end else begin
          // Stalled: hold the word; any new digest is lost.
          overrun_nxt_s = overrun_r | edge_s;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, datapath and edge-detect registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      sreg_r    <= {l{1'b0}};
      cnt_r     <= {CW{1'b0}};
      rdy_q_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      sreg_r    <= sreg_nxt_s;
      cnt_r     <= cnt_nxt_s;
      rdy_q_r   <= hash_ready;
      overrun_r <= overrun_nxt_s;
    end
  end

endmodule

// File: tb/tb_hash_out_serializer.sv
// Directed self-checking bench for hash_out_serializer (l=256, w=64, 4 words).
module tb_hash_out_serializer;

  logic         clk;
  logic         rst;
  logic [255:0] hash_text;
  logic         hash_ready;
  logic [63:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         busy;
  logic         overrun;

  int tests;
  int fails;

  logic [255:0] d1;
  logic [255:0] d2;

  hash_out_serializer #(.l(256), .w(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .hash_text  (hash_text),
    .hash_ready (hash_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] word_of(input logic [255:0] d, input int i);
    return d[255 - 64*i -: 64];
  endfunction

  // Check the full output bundle for one cycle.
  task automatic expect_out(input string tag, input logic v, input logic [63:0] d, input logic lst);
    chk({tag, ".valid"}, {255'd0, out_valid}, {255'd0, v});
    chk({tag, ".busy"},  {255'd0, busy},      {255'd0, v});
    chk({tag, ".data"},  {192'd0, out_data},  {192'd0, d});
    chk({tag, ".last"},  {255'd0, out_last},  {255'd0, lst});
  endtask

  initial begin
    int hs_cnt;
    int idx;
    logic [6:0] pat;

    tests = 0;
    fails = 0;
    d1 = {64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0011223344556677, 64'h8899AABBCCDDEEFF};
    d2 = {64'hDEADBEEF00000001, 64'hCAFEF00D00000002, 64'h1234567800000003, 64'h9ABCDEF000000004};

    // ---------------- reset ----------------
    rst = 1'b1; hash_ready = 1'b0; out_ready = 1'b0; hash_text = 256'd0;
    tick(); tick();
    expect_out("reset", 1'b0, 64'd0, 1'b0);
    chk("reset.overrun", {255'd0, overrun}, 256'd0);
    rst = 1'b0;
    tick();
    expect_out("idle", 1'b0, 64'd0, 1'b0);

    // ---------------- basic stream, out_ready high ----------------
    hash_text = d1; hash_ready = 1'b1; out_ready = 1'b1;
    tick();
    hash_ready = 1'b0; hash_text = 256'd0;
    expect_out("t1.w0", 1'b1, 64'h0123456789ABCDEF, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      expect_out($sformatf("t1.w%0d", i), 1'b1, word_of(d1, i), (i == 3));
    end
    tick();
    expect_out("t1.done", 1'b0, 64'd0, 1'b0);
    chk("t1.overrun", {255'd0, overrun}, 256'd0);

    // ---------------- backpressure 1,0,0,1,0,1,1 ----------------
    hash_text = d2; hash_ready = 1'b1; out_ready = 1'b0;
    tick();
    hash_ready = 1'b0;
    expect_out("bp.w0", 1'b1, word_of(d2, 0), 1'b0);
    pat = 7'b1101001;  // applied LSB first: 1,0,0,1,0,1,1
    idx = 0;
    hs_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      out_ready = pat[i];
      if (out_valid && out_ready) hs_cnt++;
      tick();
      if (pat[i]) idx++;
      if (idx < 4) expect_out($sformatf("bp.s%0d", i), 1'b1, word_of(d2, idx), (idx == 3));
      else         expect_out($sformatf("bp.s%0d", i), 1'b0, 64'd0, 1'b0);
    end
    chk("bp.handshakes", hs_cnt, 256'd4);
    out_ready = 1'b1;

    // ---------------- hash_ready held high 20 cycles ----------------
    hash_text = d1; hash_ready = 1'b1;
    hs_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) hs_cnt++;
      if (i == 0) chk("hold.w0", {192'd0, out_data}, {192'd0, word_of(d1, 0)});
    end
    chk("hold.words", hs_cnt, 256'd4);
    chk("hold.overrun", {255'd0, overrun}, 256'd0);
    hash_ready = 1'b0;
    tick();

    // ---------------- overrun during word 1 ----------------
    hash_text = d1; hash_ready = 1'b1;
    tick();
    hash_ready = 1'b0;
    expect_out("ov.w0", 1'b1, word_of(d1, 0), 1'b0);
    tick();
    expect_out("ov.w1", 1'b1, word_of(d1, 1), 1'b0);
    hash_text = d2; hash_ready = 1'b1;   // edge while word 1 is on the bus
    tick();
    hash_ready = 1'b0;
    expect_out("ov.w2", 1'b1, word_of(d1, 2), 1'b0);
    chk("ov.flag", {255'd0, overrun}, 256'd1);
    tick();
    expect_out("ov.w3", 1'b1, word_of(d1, 3), 1'b1);
    // Edge aligned with the final handshake chains the new digest.
    hash_text = d2; hash_ready = 1'b1;
    tick();
    hash_ready = 1'b0;
    expect_out("chain.w0", 1'b1, word_of(d2, 0), 1'b0);
    chk("chain.overrun", {255'd0, overrun}, 256'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      expect_out($sformatf("chain.w%0d", i), 1'b1, word_of(d2, i), (i == 3));
    end
    tick();
    expect_out("chain.done", 1'b0, 64'd0, 1'b0);

    // ---------------- reset mid-stream ----------------
    hash_text = d1; hash_ready = 1'b1;
    tick();
    expect_out("rs.w0", 1'b1, word_of(d1, 0), 1'b0);
    tick();
    tick();
    expect_out("rs.w2", 1'b1, word_of(d1, 2), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_out("rs.cleared", 1'b0, 64'd0, 1'b0);
    chk("rs.overrun", {255'd0, overrun}, 256'd0);
    tick();   // hash_ready still high: re-detected as a fresh edge
    expect_out("rs.restart.w0", 1'b1, word_of(d1, 0), 1'b0);
    hash_ready = 1'b0;
    for (int i = 1; i < 4; i++) begin
      tick();
      expect_out($sformatf("rs.restart.w%0d", i), 1'b1, word_of(d1, i), (i == 3));
    end
    tick();
    expect_out("rs.done", 1'b0, 64'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
